// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse period meter and its helper stages.
package pulse_meter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector on an already-synchronous level.
// The delay register resets high so a level that is already 1 at reset release is not a rise.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sig_d_q;

  always_ff @(posedge clk) begin
    if (reset) sig_d_q <= 1'b1;
    else       sig_d_q <= d;
  end

  assign rise = d & ~sig_d_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time between consecutive rising edges of signal_in.
// Counters saturate; a saturated period with no edge ends the measurement as a timeout.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             overflow,
  output logic             measuring
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;
  logic [CNT_W-1:0] high_out_q, high_out_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overflow_q, overflow_d;
  logic             rise;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .d     (signal_in),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_out_q <= '0;
      high_out_q   <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      meas_valid_q <= meas_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    meas_valid_d = 1'b0;
    overflow_d   = overflow_q;

    if (!enable) begin
      // Dropping enable abandons any measurement in progress without reporting it.
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          state_d      = ARM;
        end
        ARM: begin
          if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            state_d      = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out_d = period_cnt_q;
            high_out_d   = high_cnt_q;
            meas_valid_d = 1'b1;
            overflow_d   = 1'b0;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else if (period_cnt_q == CNT_MAX) begin
            period_out_d = CNT_MAX;
            high_out_d   = high_cnt_q;
            meas_valid_d = 1'b1;
            overflow_d   = 1'b1;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            state_d      = ARM;
          end else begin
            period_cnt_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
            if (signal_in && (high_cnt_q != CNT_MAX)) high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d      = IDLE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end
      endcase
    end
  end

  assign period_out = period_out_q;
  assign high_out   = high_out_q;
  assign meas_valid = meas_valid_q;
  assign overflow   = overflow_q;
  assign measuring  = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a 16-bit and a 4-bit instance, each with its own
// expected-result queue drained by a monitor whenever meas_valid is seen.
module tb_pulse_period_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        signal_in, enable;
  logic        sig4, en4;
  logic [15:0] p16, h16;
  logic [3:0]  p4, h4;
  logic        mv16, ov16, ms16;
  logic        mv4, ov4, ms4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic prev16 = 1'b0;
  logic prev4  = 1'b0;

  // {valid cycle[64:33], period[32:17], high[16:1], overflow[0]}
  logic [64:0] exp16_q[$];
  logic [64:0] exp4_q[$];

  pulse_period_meter #(.CNT_W(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .signal_in  (signal_in),
    .enable     (enable),
    .period_out (p16),
    .high_out   (h16),
    .meas_valid (mv16),
    .overflow   (ov16),
    .measuring  (ms16)
  );

  pulse_period_meter #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .signal_in  (sig4),
    .enable     (en4),
    .period_out (p4),
    .high_out   (h4),
    .meas_valid (mv4),
    .overflow   (ov4),
    .measuring  (ms4)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (mv16 === 1'b1) begin
      chk("valid16_back_to_back", {31'd0, prev16}, 32'd0);
      if (exp16_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected16 got period=%0d high=%0d ovf=%0d exp=none (cycle %0d)",
                 p16, h16, ov16, cyc);
      end else begin
        e = exp16_q.pop_front();
        chk("valid16_cycle", cyc, e[64:33]);
        chk("period16", {16'd0, p16}, {16'd0, e[32:17]});
        chk("high16", {16'd0, h16}, {16'd0, e[16:1]});
        chk("overflow16", {31'd0, ov16}, {31'd0, e[0]});
      end
    end
    prev16 = mv16;
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (mv4 === 1'b1) begin
      chk("valid4_back_to_back", {31'd0, prev4}, 32'd0);
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected4 got period=%0d high=%0d ovf=%0d exp=none (cycle %0d)",
                 p4, h4, ov4, cyc);
      end else begin
        e = exp4_q.pop_front();
        chk("valid4_cycle", cyc, e[64:33]);
        chk("period4", {28'd0, p4}, {16'd0, e[32:17]});
        chk("high4", {28'd0, h4}, {16'd0, e[16:1]});
        chk("overflow4", {31'd0, ov4}, {31'd0, e[0]});
      end
    end
    prev4 = mv4;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic s);
    signal_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic s);
    sig4 = s;
    @(posedge clk);
    #1;
  endtask

  // A rise driven now is registered at the next edge; the result appears right after it.
  task automatic exp16(input logic [15:0] p, input logic [15:0] h);
    exp16_q.push_back({32'(cyc + 1), p, h, 1'b0});
  endtask

  task automatic exp4(input int dly, input logic [15:0] p, input logic [15:0] h, input logic o);
    exp4_q.push_back({32'(cyc + dly), p, h, o});
  endtask

  task automatic square(input int hi, input int lo, input bit rep,
                        input logic [15:0] p, input logic [15:0] h);
    if (rep) exp16(p, h);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic disable16();
    enable = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("measuring_after_disable", {31'd0, ms16}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_period16"}, {16'd0, p16}, 32'd0);
    chk({tag, "_high16"}, {16'd0, h16}, 32'd0);
    chk({tag, "_valid16"}, {31'd0, mv16}, 32'd0);
    chk({tag, "_overflow16"}, {31'd0, ov16}, 32'd0);
    chk({tag, "_measuring16"}, {31'd0, ms16}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; signal_in = 1'b0; en4 = 1'b0; sig4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");
    chk("reset_period4", {28'd0, p4}, 32'd0);
    chk("reset_measuring4", {31'd0, ms4}, 32'd0);

    // 3 high / 2 low: first edge arms, then period 5, high 3
    enable = 1'b1;
    step(1'b0); step(1'b0);
    chk("armed_not_measuring", {31'd0, ms16}, 32'd0);
    square(3, 2, 1'b0, 16'd0, 16'd0);
    chk("measuring_after_arm", {31'd0, ms16}, 32'd1);
    repeat (5) square(3, 2, 1'b1, 16'd5, 16'd3);
    disable16();

    // Alternating every cycle: minimum period 2, high 1
    enable = 1'b1;
    step(1'b0); step(1'b0);
    square(1, 1, 1'b0, 16'd0, 16'd0);
    repeat (8) square(1, 1, 1'b1, 16'd2, 16'd1);
    disable16();

    // High held through reset release is not an edge
    signal_in = 1'b1; reset = 1'b1;
    step(1'b1); step(1'b1);
    reset = 1'b0; enable = 1'b1;
    repeat (5) step(1'b1);
    chk("no_arm_on_held_high", {31'd0, ms16}, 32'd0);
    step(1'b0);
    step(1'b1);
    chk("arm_after_real_edge", {31'd0, ms16}, 32'd1);
    step(1'b1); step(1'b0); step(1'b0);
    exp16(16'd4, 16'd2);
    step(1'b1);
    step(1'b0);
    disable16();

    // enable dropped on the same cycle as a rise
    enable = 1'b1;
    step(1'b0); step(1'b0);
    square(3, 2, 1'b0, 16'd0, 16'd0);
    square(3, 2, 1'b1, 16'd5, 16'd3);
    enable = 1'b0;
    step(1'b1);
    chk("drop_measuring", {31'd0, ms16}, 32'd0);
    chk("drop_period_held", {16'd0, p16}, 32'd5);
    chk("drop_high_held", {16'd0, h16}, 32'd3);
    step(1'b0); step(1'b0);

    // Reset pulse mid-period of a 10-cycle wave, then re-arm
    enable = 1'b1;
    step(1'b0); step(1'b0);
    square(5, 5, 1'b0, 16'd0, 16'd0);
    square(5, 5, 1'b1, 16'd10, 16'd5);
    exp16(16'd10, 16'd5);
    step(1'b1); step(1'b1);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    check_reset_outputs("midreset");
    step(1'b1); step(1'b1);
    repeat (5) step(1'b0);
    square(5, 5, 1'b0, 16'd0, 16'd0);
    chk("rearm_after_reset", {31'd0, ms16}, 32'd1);
    square(5, 5, 1'b1, 16'd10, 16'd5);
    disable16();

    // CNT_W=4: rise landing exactly on a saturated count, then stuck-high timeout
    en4 = 1'b1;
    step4(1'b0); step4(1'b0);
    exp4(16, 16'd15, 16'd14, 1'b0);
    step4(1'b1);
    repeat (13) step4(1'b1);
    step4(1'b0);
    exp4(16, 16'd15, 16'd15, 1'b1);
    step4(1'b1);
    repeat (16) step4(1'b1);
    chk("timeout_back_to_arm", {31'd0, ms4}, 32'd0);
    repeat (3) step4(1'b1);
    chk("stuck_no_rearm", {31'd0, ms4}, 32'd0);
    step4(1'b0);
    step4(1'b1);
    chk("rearm_after_timeout", {31'd0, ms4}, 32'd1);
    en4 = 1'b0;
    step4(1'b0); step4(1'b0);
    chk("measuring4_after_disable", {31'd0, ms4}, 32'd0);

    repeat (3) step(1'b0);
    chk("pending16_drained", exp16_q.size(), 32'd0);
    chk("pending4_drained", exp4_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
